// File: rtl/lab2_datapath_if.sv
// ---------------------------------------------------------------------------
// lab2_datapath_if : controller <-> datapath control/data bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface lab2_datapath_if #(
  parameter int W = 4
);
  logic         R0en;
  logic         R1en;
  logic [1:0]   R0muxsel;
  logic [1:0]   R1muxsel;
  logic [1:0]   Aluasel;
  logic         Alubsel;
  logic [2:0]   Aluop;
  logic         Accpl;
  logic         Qpl;
  logic         Qmuxsel;
  logic         Emuxsel;
  logic [W-1:0] Datain;
  logic [W-1:0] R0out;
  logic [W-1:0] R1out;
  logic [W-1:0] Accout;
  logic [W-1:0] Qout;
  logic         Q0;
  logic [1:0]   Errorout;

  modport master (
    output R0en, R1en, R0muxsel, R1muxsel, Aluasel, Alubsel, Aluop,
           Accpl, Qpl, Qmuxsel, Emuxsel, Datain,
    input  R0out, R1out, Accout, Qout, Q0, Errorout
  );

  modport slave (
    input  R0en, R1en, R0muxsel, R1muxsel, Aluasel, Alubsel, Aluop,
           Accpl, Qpl, Qmuxsel, Emuxsel, Datain,
    output R0out, R1out, Accout, Qout, Q0, Errorout
  );
endinterface

`default_nettype wire

// File: rtl/lab2_datapath.sv
// ---------------------------------------------------------------------------
// lab2_datapath : W-bit calculator datapath (R0, R1, Booth Acc/Q/E, shared ALU)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lab2_datapath #(
  parameter int W = 4
) (
  input  wire logic        clk,
  input  wire logic        R0rst,
  input  wire logic        R1rst,
  input  wire logic        Accrst,
  input  wire logic        Qrst,
  input  wire logic        Erst,
  lab2_datapath_if.slave   bus
);

  logic [W-1:0] r_r0;
  logic [W-1:0] r_r1;
  logic [W-1:0] r_acc;
  logic [W-1:0] r_q;
  logic [1:0]   r_e;

  logic [W-1:0] w_alu_a;
  logic [W-1:0] w_alu_b;
  logic [W-1:0] w_alu_res;
  logic         w_ovf;
  logic         w_shift;

  always_comb begin
    case (bus.Aluasel)
      2'b00:   w_alu_a = r_r0;
      2'b01:   w_alu_a = r_r1;
      2'b10:   w_alu_a = r_acc;
      default: w_alu_a = '0;
    endcase
    w_alu_b = bus.Alubsel ? r_r1 : r_r0;
  end

  // Carry-out is dropped; signed overflow only meaningful for add/sub.
  always_comb begin
    w_alu_res = w_alu_a;
    w_ovf     = 1'b0;
    case (bus.Aluop)
      3'b000: begin
        w_alu_res = w_alu_a + w_alu_b;
        w_ovf     = (w_alu_a[W-1] == w_alu_b[W-1]) && (w_alu_res[W-1] != w_alu_a[W-1]);
      end
      3'b001: begin
        w_alu_res = w_alu_a - w_alu_b;
        w_ovf     = (w_alu_a[W-1] != w_alu_b[W-1]) && (w_alu_res[W-1] != w_alu_a[W-1]);
      end
      3'b010:  w_alu_res = w_alu_a;
      3'b011:  w_alu_res = w_alu_a & w_alu_b;
      3'b100:  w_alu_res = w_alu_a | w_alu_b;
      3'b101:  w_alu_res = w_alu_a ^ w_alu_b;
      3'b110:  w_alu_res = ~w_alu_a;
      default: w_alu_res = {w_alu_a[W-1], w_alu_a[W-1:1]};
    endcase
  end

  // Any parallel load on Acc or Q wins over the Booth shift.
  assign w_shift = ~bus.Emuxsel & ~bus.Accpl & ~bus.Qpl;

  always_ff @(posedge clk or posedge R0rst) begin
    if (R0rst) begin
      r_r0 <= '0;
    end else if (bus.R0en) begin
      case (bus.R0muxsel)
        2'b00:   r_r0 <= w_alu_res;
        2'b01:   r_r0 <= bus.Datain;
        2'b10:   r_r0 <= r_acc;
        default: r_r0 <= r_r0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge R1rst) begin
    if (R1rst) begin
      r_r1 <= '0;
    end else if (bus.R1en) begin
      case (bus.R1muxsel)
        2'b00:   r_r1 <= w_alu_res;
        2'b01:   r_r1 <= bus.Datain;
        2'b10:   r_r1 <= r_q;
        default: r_r1 <= r_r1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge Accrst) begin
    if (Accrst) begin
      r_acc <= '0;
    end else if (bus.Accpl) begin
      r_acc <= w_alu_res;
    end else if (w_shift) begin
      r_acc <= {r_acc[W-1], r_acc[W-1:1]};
    end
  end

  always_ff @(posedge clk or posedge Qrst) begin
    if (Qrst) begin
      r_q <= '0;
    end else if (bus.Qpl) begin
      if (!bus.Qmuxsel) begin
        r_q <= r_r0;
      end
    end else if (w_shift) begin
      r_q <= {r_acc[0], r_q[W-1:1]};
    end
  end

  // E[1] is the Booth Q-1 bit; E[0] is a sticky overflow flag for ALU writes into R0.
  always_ff @(posedge clk or posedge Erst) begin
    if (Erst) begin
      r_e <= 2'b00;
    end else begin
      if (w_shift) begin
        r_e[1] <= r_q[0];
      end
      if (bus.R0en && (bus.R0muxsel == 2'b00) && w_ovf) begin
        r_e[0] <= 1'b1;
      end
    end
  end

  assign bus.R0out    = r_r0;
  assign bus.R1out    = r_r1;
  assign bus.Accout   = r_acc;
  assign bus.Qout     = r_q;
  assign bus.Q0       = r_q[0];
  assign bus.Errorout = r_e;

endmodule

`default_nettype wire

// File: tb/tb_lab2_datapath.sv
// ---------------------------------------------------------------------------
// tb_lab2_datapath : directed scoreboard bench for lab2_datapath (W=4)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lab2_datapath;

    localparam int W = 4;
    localparam int c_SEL_R0 = 0;
    localparam int c_SEL_R1 = 1;
    localparam int c_SEL_ACC = 2;
    localparam int c_SEL_Q = 3;
    localparam int c_SEL_E = 4;

    typedef struct {
        int         sel;
        logic [3:0] val;
        string      name;
    } exp_t;

    logic clk;
    logic R0rst, R1rst, Accrst, Qrst, Erst;
    logic chk_tog;
    exp_t sbq[$];
    int   errors;
    int   checks;

    logic [2:0] ops   [5] = '{3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    logic [3:0] opexp [5] = '{4'b1000, 4'b1110, 4'b0110, 4'b0011, 4'b1110};

    lab2_datapath_if #(.W(W)) dif ();

    lab2_datapath #(.W(W)) dut (
        .clk    (clk),
        .R0rst  (R0rst),
        .R1rst  (R1rst),
        .Accrst (Accrst),
        .Qrst   (Qrst),
        .Erst   (Erst),
        .bus    (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] pick(input int sel);
        case (sel)
            c_SEL_R0:  return dif.R0out;
            c_SEL_R1:  return dif.R1out;
            c_SEL_ACC: return dif.Accout;
            c_SEL_Q:   return dif.Qout;
            default:   return {2'b00, dif.Errorout};
        endcase
    endfunction

    // Monitor: drains the scoreboard on every falling edge or on an explicit request.
    always @(negedge clk or chk_tog) begin
        while (sbq.size() > 0) begin
            exp_t       e;
            logic [3:0] a;
            e = sbq.pop_front();
            a = pick(e.sel);
            checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s: got %b, expected %b", e.name, a, e.val);
            end
        end
    end

    task automatic expect_v(input int sel, input logic [3:0] v, input string n);
        exp_t e;
        e.sel  = sel;
        e.val  = v;
        e.name = n;
        sbq.push_back(e);
    endtask

    task automatic check_now();
        chk_tog = ~chk_tog;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dif.R0en     = 1'b0;
        dif.R1en     = 1'b0;
        dif.R0muxsel = 2'b11;
        dif.R1muxsel = 2'b11;
        dif.Aluasel  = 2'b00;
        dif.Alubsel  = 1'b1;
        dif.Aluop    = 3'b010;
        dif.Accpl    = 1'b0;
        dif.Qpl      = 1'b0;
        dif.Qmuxsel  = 1'b1;
        dif.Emuxsel  = 1'b1;
    endtask

    task automatic load_r0(input logic [3:0] v);
        idle();
        dif.Datain   = v;
        dif.R0en     = 1'b1;
        dif.R0muxsel = 2'b01;
        tick();
        idle();
    endtask

    task automatic load_r1(input logic [3:0] v);
        idle();
        dif.Datain   = v;
        dif.R1en     = 1'b1;
        dif.R1muxsel = 2'b01;
        tick();
        idle();
    endtask

    task automatic alu_to_r0(input logic [2:0] op);
        idle();
        dif.Aluasel  = 2'b00;
        dif.Alubsel  = 1'b1;
        dif.Aluop    = op;
        dif.R0muxsel = 2'b00;
        dif.R0en     = 1'b1;
        tick();
        idle();
    endtask

    task automatic pulse_erst();
        Erst = 1'b1;
        #1;
        Erst = 1'b0;
    endtask

    // Acts as the Booth controller: decisions come from Q0/E[1] as the real one would.
    task automatic booth(input logic [3:0] plier, input logic [3:0] cand);
        load_r0(plier);
        load_r1(cand);
        Accrst = 1'b1;
        Erst   = 1'b1;
        #1;
        Accrst = 1'b0;
        Erst   = 1'b0;
        dif.Qpl     = 1'b1;
        dif.Qmuxsel = 1'b0;
        dif.Emuxsel = 1'b0;
        tick();
        idle();
        for (int i = 0; i < W; i++) begin
            if ({dif.Q0, dif.Errorout[1]} == 2'b01 || {dif.Q0, dif.Errorout[1]} == 2'b10) begin
                dif.Aluasel = 2'b10;
                dif.Alubsel = 1'b1;
                dif.Aluop   = dif.Q0 ? 3'b001 : 3'b000;
                dif.Accpl   = 1'b1;
                dif.Emuxsel = 1'b0;
                tick();
                idle();
            end
            dif.Emuxsel = 1'b0;
            tick();
            idle();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        errors  = 0;
        checks  = 0;
        chk_tog = 1'b0;
        dif.Datain = '0;
        idle();
        R0rst = 1'b1; R1rst = 1'b1; Accrst = 1'b1; Qrst = 1'b1; Erst = 1'b1;
        #2;
        expect_v(c_SEL_R0, 4'd0, "reset_r0");
        expect_v(c_SEL_R1, 4'd0, "reset_r1");
        expect_v(c_SEL_ACC, 4'd0, "reset_acc");
        expect_v(c_SEL_Q, 4'd0, "reset_q");
        expect_v(c_SEL_E, 4'd0, "reset_e");
        check_now();
        R0rst = 1'b0; R1rst = 1'b0; Accrst = 1'b0; Qrst = 1'b0; Erst = 1'b0;

        // Load both operands from Datain on one edge
        dif.Datain   = 4'd3;
        dif.R0en     = 1'b1;
        dif.R1en     = 1'b1;
        dif.R0muxsel = 2'b01;
        dif.R1muxsel = 2'b01;
        tick();
        expect_v(c_SEL_R0, 4'd3, "load_r0");
        expect_v(c_SEL_R1, 4'd3, "load_r1");
        checks++;
        if (dif.R0out !== 4'd3 || dif.R1out !== 4'd3) begin
            errors++;
            $display("FAIL load_direct: got R0=%b R1=%b, expected 0011 0011", dif.R0out, dif.R1out);
        end
        idle();

        // Signed add overflow 7+1 and stickiness of E[0]
        load_r0(4'd7);
        load_r1(4'd1);
        alu_to_r0(3'b000);
        expect_v(c_SEL_R0, 4'b1000, "add_ovf_r0");
        expect_v(c_SEL_E, 4'b0001, "add_ovf_e");
        load_r0(4'd2);
        expect_v(c_SEL_E, 4'b0001, "ovf_sticky");
        @(negedge clk);
        #2;
        Erst = 1'b1;
        #1;
        expect_v(c_SEL_E, 4'b0000, "erst_async");
        check_now();
        Erst = 1'b0;

        // Subtraction: 2-3 no overflow, -8-1 overflow
        load_r1(4'd3);
        alu_to_r0(3'b001);
        expect_v(c_SEL_R0, 4'b1111, "sub_r0");
        expect_v(c_SEL_E, 4'b0000, "sub_no_ovf");
        load_r0(4'b1000);
        load_r1(4'b0001);
        alu_to_r0(3'b001);
        expect_v(c_SEL_R0, 4'b0111, "sub_ovf_r0");
        expect_v(c_SEL_E, 4'b0001, "sub_ovf_e");

        // Asynchronous R0 reset overrides an active enable
        load_r0(4'd5);
        expect_v(c_SEL_R0, 4'd5, "r0_pre_rst");
        @(negedge clk);
        #2;
        R0rst        = 1'b1;
        dif.R0en     = 1'b1;
        dif.R0muxsel = 2'b01;
        dif.Datain   = 4'd9;
        #1;
        expect_v(c_SEL_R0, 4'd0, "r0rst_async");
        check_now();
        checks++;
        if (dif.R0out !== 4'd0) begin
            errors++;
            $display("FAIL r0rst_direct: got %b, expected 0000", dif.R0out);
        end
        tick();
        expect_v(c_SEL_R0, 4'd0, "r0rst_over_en");
        @(negedge clk);
        #1;
        R0rst = 1'b0;
        idle();

        // Hold select with enable active; zero A operand
        load_r0(4'd6);
        dif.R0en     = 1'b1;
        dif.R0muxsel = 2'b11;
        dif.Datain   = 4'd1;
        tick();
        expect_v(c_SEL_R0, 4'd6, "r0_hold_sel");
        idle();
        dif.Aluasel  = 2'b11;
        dif.Aluop    = 3'b010;
        dif.R0muxsel = 2'b00;
        dif.R0en     = 1'b1;
        tick();
        expect_v(c_SEL_R0, 4'd0, "alu_zero_a");
        idle();

        // Booth 3 x 5 = 15, read back through R0<-Acc / R1<-Q on the same edge
        booth(4'd3, 4'd5);
        expect_v(c_SEL_ACC, 4'b0000, "booth35_acc");
        expect_v(c_SEL_Q, 4'b1111, "booth35_q");
        checks++;
        if ({dif.Accout, dif.Qout} !== 8'b0000_1111) begin
            errors++;
            $display("FAIL booth35_direct: got %b_%b, expected 0000_1111", dif.Accout, dif.Qout);
        end
        dif.R0muxsel = 2'b10;
        dif.R1muxsel = 2'b10;
        dif.R0en     = 1'b1;
        dif.R1en     = 1'b1;
        tick();
        expect_v(c_SEL_R0, 4'b0000, "booth35_r0");
        expect_v(c_SEL_R1, 4'b1111, "booth35_r1");
        idle();

        // Booth 3 x (-2) = -6
        booth(4'b0011, 4'b1110);
        expect_v(c_SEL_ACC, 4'b1111, "booth3m2_acc");
        expect_v(c_SEL_Q, 4'b1010, "booth3m2_q");
        checks++;
        if ({dif.Accout, dif.Qout} !== 8'b1111_1010) begin
            errors++;
            $display("FAIL booth3m2_direct: got %b_%b, expected 1111_1010", dif.Accout, dif.Qout);
        end

        // Logic ops from R0=1100, R1=1010
        pulse_erst();
        load_r1(4'b1010);
        for (int i = 0; i < 5; i++) begin
            load_r0(4'b1100);
            alu_to_r0(ops[i]);
            expect_v(c_SEL_R0, opexp[i], $sformatf("logic_op_%b", ops[i]));
            expect_v(c_SEL_E, 4'b0000, $sformatf("logic_e_%b", ops[i]));
        end

        repeat (2) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
